seq_gates_run_counter: RTL and testbench

Downstream consumer of the registered two-input AND gate stage. Takes that stage's 1-bit output stream and measures each run of consecutive 1s in cycles. Completed run lengths go into a small FIFO, which software-visible logic or a test harness drains over a val/rdy interface. Overflow handling and an optional dropped-run counter cover a stalled consumer.

---
 rtl/seq_gates_run_counter.sv | 138 +++++++++++++
 tb/tb_seq_gates_run_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_gates_run_counter.sv
// Measures runs of consecutive 1s on in_ and queues the run lengths in a small FIFO drained over val/rdy.
// Optional RUN_CNT_DROP_CNT_EN adds a saturating count of runs dropped on a full FIFO.
module seq_gates_run_counter #(
  parameter int unsigned p_cnt_nbits   = 8,
  parameter int unsigned p_num_entries = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_cnt_nbits-1:0] out_msg,
  output logic                   busy
`ifdef RUN_CNT_DROP_CNT_EN
  ,
  output logic [p_cnt_nbits-1:0] drop_cnt
`endif
);

  localparam int unsigned PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [p_cnt_nbits-1:0]   cnt_q, cnt_d;
  logic [p_cnt_nbits-1:0]   mem_q [p_num_entries];
  logic [p_cnt_nbits-1:0]   mem_d [p_num_entries];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic                     out_val_q, out_val_d;
  logic [p_cnt_nbits-1:0]   out_msg_q, out_msg_d;
  logic                     busy_q, busy_d;
  logic [p_cnt_nbits-1:0]   drop_q, drop_d;

  logic enq, deq, full, drop;

  // Run-length FSM, FIFO pointers and the registered view of the FIFO head.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    enq      = 1'b0;
    drop     = 1'b0;

    full = (occ_q == OCC_W'(p_num_entries));
    deq  = out_val_q & out_rdy;

    case (state_q)
      IDLE: begin
        if (in_) begin
          state_d = RUN;
          cnt_d   = p_cnt_nbits'(1);
        end
      end
      RUN: begin
        if (in_) begin
          if (cnt_q != '1) cnt_d = cnt_q + p_cnt_nbits'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          enq     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still admits a new entry when the head leaves in the same cycle.
    if (enq && full && !deq) begin
      enq  = 1'b0;
      drop = 1'b1;
    end

    if (enq) begin
      mem_d[wr_ptr_q] = cnt_q;
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (deq) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);

    case ({enq, deq})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (drop && drop_q != '1) drop_d = drop_q + p_cnt_nbits'(1);

    out_val_d = (occ_d != '0);
    out_msg_d = out_val_d ? mem_d[rd_ptr_d] : '0;
    busy_d    = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign busy    = busy_q;

`ifdef RUN_CNT_DROP_CNT_EN
  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop_q;
`endif

endmodule

// File: tb/tb_seq_gates_run_counter.sv
// Directed bench for seq_gates_run_counter: a queue-based run-length model checked every cycle plus literal spot checks.
module tb_seq_gates_run_counter;

  localparam int unsigned NB    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          MAXV  = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_;
  logic          out_rdy;
  logic          out_val;
  logic [NB-1:0] out_msg;
  logic          busy;
`ifdef RUN_CNT_DROP_CNT_EN
  logic [NB-1:0] drop_cnt;
`endif

  seq_gates_run_counter #(.p_cnt_nbits(NB), .p_num_entries(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_     (in_),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .busy    (busy)
`ifdef RUN_CNT_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // Reference model: a queue of completed run lengths and the current run.
  int q[$];
  int run_len = 0;
  bit m_busy  = 1'b0;
  int m_drop  = 0;

  always @(posedge clk) begin
    bit deq;
    bit ended;
    int ended_len;
    if (reset) begin
      q.delete();
      run_len = 0;
      m_busy  = 1'b0;
      m_drop  = 0;
    end else begin
      deq   = (q.size() > 0) && out_rdy;
      ended = 1'b0;
      ended_len = 0;
      if (in_) begin
        run_len = m_busy ? ((run_len < MAXV) ? run_len + 1 : MAXV) : 1;
        m_busy  = 1'b1;
      end else if (m_busy) begin
        ended     = 1'b1;
        ended_len = run_len;
        run_len   = 0;
        m_busy    = 1'b0;
      end
      if (deq) void'(q.pop_front());
      if (ended) begin
        if (q.size() < DEPTH) q.push_back(ended_len);
        else if (m_drop < MAXV) m_drop++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_out_val", int'(out_val), (q.size() > 0) ? 1 : 0);
      chk("model_out_msg", int'(out_msg), (q.size() > 0) ? q[0] : 0);
      chk("model_busy", int'(busy), int'(m_busy));
`ifdef RUN_CNT_DROP_CNT_EN
      chk("model_drop_cnt", int'(drop_cnt), m_drop);
`endif
    end
  end

  task automatic step(input bit i, input bit r);
    in_     = i;
    out_rdy = r;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int stayed;
    reset = 1'b1; in_ = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    do_reset(2);
    chk("reset_out_val", int'(out_val), 0);
    chk("reset_out_msg", int'(out_msg), 0);
    chk("reset_busy", int'(busy), 0);

    // Basic run of three.
    step(0, 1); step(1, 1); step(1, 1); step(1, 1);
    step(0, 1);
    chk("basic_val", int'(out_val), 1);
    chk("basic_msg", int'(out_msg), 3);
    step(0, 1);
    chk("basic_drained_val", int'(out_val), 0);
    chk("basic_drained_msg", int'(out_msg), 0);

    // Back-to-back runs separated by one 0.
    step(1, 0); chk("b2b_busy_first", int'(busy), 1);
    step(0, 0); chk("b2b_busy_gap", int'(busy), 0);
    step(1, 0); step(1, 0);
    step(0, 0);
    chk("b2b_head_held", int'(out_msg), 1);
    chk("b2b_model_depth", q.size(), 2);
    step(0, 1); chk("b2b_second", int'(out_msg), 2);
    step(0, 1); chk("b2b_empty", int'(out_val), 0);

    // Saturation over a 300-cycle run.
    repeat (300) step(1, 0);
    chk("sat_busy", int'(busy), 1);
    step(0, 0);
    chk("sat_msg", int'(out_msg), 255);
    step(0, 1);
    chk("sat_empty", int'(out_val), 0);

    // Full FIFO, stalled consumer: fifth run dropped.
    do_reset(1);
    repeat (5) begin step(1, 0); step(1, 0); step(0, 0); end
    chk("full_depth", q.size(), 4);
    chk("full_msg", int'(out_msg), 2);
`ifdef RUN_CNT_DROP_CNT_EN
    chk("full_drop_cnt", int'(drop_cnt), 1);
`endif
    stayed = 0;
    for (int k = 0; k < 8 && out_val; k++) begin
      chk("full_drain_msg", int'(out_msg), 2);
      step(0, 1);
      stayed++;
    end
    chk("full_drained_count", stayed, 4);

    // Full FIFO with a dequeue on the fifth run's ending edge.
    do_reset(1);
    repeat (4) begin step(1, 0); step(1, 0); step(0, 0); end
    step(1, 0); step(1, 0); step(0, 1);
    chk("fullpair_depth", q.size(), 4);
`ifdef RUN_CNT_DROP_CNT_EN
    chk("fullpair_drop_cnt", int'(drop_cnt), 0);
`endif
    stayed = 0;
    for (int k = 0; k < 8 && out_val; k++) begin
      step(0, 1);
      stayed++;
    end
    chk("fullpair_drained_count", stayed, 4);

    // Reset in the middle of a run with entries queued.
    step(1, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
    repeat (5) step(1, 0);
    chk("mid_busy_before", int'(busy), 1);
    do_reset(1);
    chk("mid_reset_val", int'(out_val), 0);
    chk("mid_reset_busy", int'(busy), 0);
`ifdef RUN_CNT_DROP_CNT_EN
    chk("mid_reset_drop", int'(drop_cnt), 0);
`endif
    step(1, 0); step(0, 0);
    chk("post_reset_val", int'(out_val), 1);
    chk("post_reset_msg", int'(out_msg), 1);
    step(0, 1);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
